usb2_ep_sched: RTL and testbench
================================

Name: usb2_ep_sched

Overview:
Transaction scheduler between the USB 2.0 packet layer and the endpoint buffer set (EP0 control, EP1 IN, EP2 OUT).
- On each decoded token it selects the endpoint and sequences the buffer handshakes (arm/commit) and data-toggle advance.
- It tells the packet layer when to transmit data and which handshake PID to return.
- One transaction in flight at a time; drives the sel_endp mux of the protocol layer.

Parameters:
- EP_IN_MASK, 16'h0003, bit n set = endpoint n accepts IN tokens.
- EP_OUT_MASK, 16'h0005, bit n set = endpoint n accepts OUT tokens; SETUP is accepted only on endpoint 0 regardless of mask.
- TIMEOUT, 12'd1000, phy_clk cycles allowed in any wait state before abort.

Ports:
- phy_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tok_valid  in  1  one-cycle token strobe.
- tok_pid  in  2  0=OUT, 1=IN, 2=SETUP, 3=reserved.
- tok_endp  in  4  token endpoint number.
- sel_endp  out  4  endpoint select to buffer mux.
- buf_out_hasdata  in  1  selected endpoint has armed IN data.
- buf_out_len  in  10  selected endpoint IN data length.
- buf_out_arm  out  1  release the IN buffer after host ACK; level.
- buf_out_arm_ack  in  1  acknowledges buf_out_arm.
- buf_in_ready  in  1  selected OUT buffer can accept a packet.
- buf_in_commit  out  1  commit a received packet; level.
- buf_in_commit_len  out  10  committed byte count.
- buf_in_commit_ack  in  1  acknowledges buf_in_commit.
- tx_start  out  1  pulse: packet layer sends DATAx from the selected buffer.
- tx_len  out  10  bytes to send.
- tx_done  in  1  pulse: data packet sent.
- rx_done  in  1  pulse: data packet received into the buffer.
- rx_len  in  10  received byte count, valid with rx_done.
- rx_crc_ok  in  1  CRC16 good, valid with rx_done.
- hs_rx_ack  in  1  pulse: host ACK received.
- hs_send  out  1  pulse: send a handshake.
- hs_pid  out  2  0=ACK, 1=NAK, 2=STALL; valid with hs_send.
- data_toggle_act  out  1  pulse: advance the selected endpoint's toggle.
- busy  out  1  high when state is not IDLE.
- err_timeout  out  1  one-cycle pulse on any timeout abort.

Behaviour:
- Reset values: every output is 0 and the state is IDLE. A reset mid-transaction drops buf_out_arm and buf_in_commit at the next edge; nothing is committed or toggled.
- IDLE
  - tok_valid with a legal pid/endpoint latches sel_endp = tok_endp on the same edge.
  - IN goes to IN_CHK. OUT/SETUP goes to OUT_RX with nak_flag = ~buf_in_ready for OUT; SETUP sets nak_flag = 0 (SETUP is always accepted).
  - Illegal combinations (pid 3, endpoint not in mask, SETUP on endpoint ≠ 0) are ignored: no response, stay IDLE.
- tok_valid in any non-IDLE state is ignored.
- IN_CHK (1 cycle)
  - If buf_out_hasdata: pulse tx_start with tx_len = buf_out_len, go to IN_TX.
  - Else: hs_send with NAK, go to IDLE.
- IN_TX: wait for tx_done, then go to IN_WAIT.
- IN_WAIT: on hs_rx_ack, assert buf_out_arm and go to IN_ARM.
- IN_ARM: hold buf_out_arm until buf_out_arm_ack, then deassert it. data_toggle_act pulses in the same cycle; go to IDLE.
- OUT_RX: wait for rx_done.
  - ~rx_crc_ok: go to IDLE silently.
  - nak_flag: hs_send with NAK, go to IDLE.
  - Otherwise: buf_in_commit = 1 with buf_in_commit_len = rx_len (registered), go to OUT_COMMIT.
- OUT_COMMIT: hold buf_in_commit until buf_in_commit_ack, then deassert it. In the same cycle pulse hs_send with ACK and data_toggle_act; go to IDLE.
- Timeout
  - A 12-bit counter clears on each state change and increments in IN_TX, IN_WAIT, OUT_RX, IN_ARM and OUT_COMMIT.
  - When it reaches TIMEOUT-1, go to IDLE and pulse err_timeout. No toggle and no handshake.
  - An IN timeout leaves the buffer unarmed, so data is kept for retry.
  - The counter saturates and never wraps.
- Simultaneous events: if an awaited event and the timeout occur in the same cycle, the event wins.
- Zero-length packets: tx_len = 0 and rx_len = 0 are legal and follow the same flow.

Optional Feature:
- Macro USB2_EP_SCHED_STALL_EN.
- With the macro defined:
  - Added inputs: halt_set (1), halt_clr (1), halt_endp (4). Added output: halted (16), a per-endpoint halt register that resets to 0. halt_clr wins over halt_set on the same endpoint.
  - A legal IN or OUT token to a halted endpoint gets hs_send with STALL (OUT only after rx_done); no buffer action, no toggle.
  - SETUP clears the EP0 halt bit and proceeds normally.
- Without the macro: STALL is never issued and the ports do not exist.

Test Plan:
- IN on EP1 with hasdata=1, len=64 → tx_start with tx_len=64; after tx_done and hs_rx_ack, buf_out_arm is held until ack; one data_toggle_act; busy returns to 0.
- IN on EP1 with hasdata=0 → hs_send NAK (hs_pid=1) 1 cycle after IN_CHK is entered; no tx_start, no toggle.
- OUT on EP2 with buf_in_ready=1, rx_len=512, crc ok → commit_len=512 held until ack, then ACK + toggle. Same with buf_in_ready=0 → NAK and no commit.
- SETUP on EP0 with buf_in_ready=0, rx_len=8 → committed and ACKed. SETUP on EP2 and pid=3 → ignored, busy stays 0.
- IN with no hs_rx_ack → err_timeout exactly TIMEOUT cycles after entering IN_WAIT, no arm, no toggle. Reset asserted during OUT_COMMIT → buf_in_commit low next cycle, all outputs 0.
- STALL_EN: halt EP2, send OUT → STALL after rx_done. halt_clr together with halt_set → not halted. SETUP clears the EP0 halt bit.

Source files
------------

// File: rtl/usb2_ep_sched.sv
// USB 2.0 endpoint transaction scheduler: token decode, IN arm / OUT commit handshakes and data-toggle advance.
// Optional endpoint halt/STALL support is compiled in by defining USB2_EP_SCHED_STALL_EN.
module usb2_ep_sched #(
    parameter logic [15:0] EP_IN_MASK  = 16'h0003,
    parameter logic [15:0] EP_OUT_MASK = 16'h0005,
    parameter logic [11:0] TIMEOUT     = 12'd1000
) (
    input  logic        phy_clk,
    input  logic        reset,
    input  logic        tok_valid,
    input  logic [1:0]  tok_pid,
    input  logic [3:0]  tok_endp,
    output logic [3:0]  sel_endp,
    input  logic        buf_out_hasdata,
    input  logic [9:0]  buf_out_len,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic        tx_start,
    output logic [9:0]  tx_len,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [9:0]  rx_len,
    input  logic        rx_crc_ok,
    input  logic        hs_rx_ack,
    output logic        hs_send,
    output logic [1:0]  hs_pid,
    output logic        data_toggle_act,
    output logic        busy,
    output logic        err_timeout
`ifdef USB2_EP_SCHED_STALL_EN
    ,
    input  logic        halt_set,
    input  logic        halt_clr,
    input  logic [3:0]  halt_endp,
    output logic [15:0] halted
`endif
);

    localparam logic [1:0] PID_OUT   = 2'd0;
    localparam logic [1:0] PID_IN    = 2'd1;
    localparam logic [1:0] PID_SETUP = 2'd2;

    localparam logic [1:0] HS_ACK   = 2'd0;
    localparam logic [1:0] HS_NAK   = 2'd1;
    localparam logic [1:0] HS_STALL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN_CHK,
        S_IN_TX,
        S_IN_WAIT,
        S_IN_ARM,
        S_OUT_RX,
        S_OUT_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        nak_q, nak_d;
    logic        stall_q, stall_d;
    logic [3:0]  sel_q, sel_d;
    logic [9:0]  commit_len_q, commit_len_d;
    logic        tx_start_q, tx_start_d;
    logic [9:0]  tx_len_q, tx_len_d;
    logic        hs_send_q, hs_send_d;
    logic [1:0]  hs_pid_q, hs_pid_d;
    logic        toggle_q, toggle_d;
    logic        err_q, err_d;

    logic        tok_legal;
    logic        ep_halted;
    logic        waiting;
    logic        timeout_hit;

    always_comb begin
        tok_legal = 1'b0;
        case (tok_pid)
            PID_IN:    tok_legal = EP_IN_MASK[tok_endp];
            PID_OUT:   tok_legal = EP_OUT_MASK[tok_endp];
            PID_SETUP: tok_legal = (tok_endp == 4'd0);
            default:   tok_legal = 1'b0;
        endcase
    end

`ifdef USB2_EP_SCHED_STALL_EN
    logic [15:0] halted_q, halted_d;
    logic        setup_clr;

    // An accepted SETUP always recovers a halted control endpoint.
    assign setup_clr = (state_q == S_IDLE) && tok_valid && tok_legal && (tok_pid == PID_SETUP);
    assign ep_halted = halted_q[tok_endp];

    for (genvar gi = 0; gi < 16; gi++) begin : g_halt
        logic hit_set, hit_clr;
        assign hit_set = halt_set && (halt_endp == 4'(gi));
        assign hit_clr = (halt_clr && (halt_endp == 4'(gi))) || ((gi == 0) && setup_clr);
        assign halted_d[gi] = hit_clr ? 1'b0 : (hit_set ? 1'b1 : halted_q[gi]);
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            halted_q <= '0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign ep_halted = 1'b0;
`endif

    assign waiting = (state_q == S_IN_TX) || (state_q == S_IN_WAIT) || (state_q == S_IN_ARM) ||
                     (state_q == S_OUT_RX) || (state_q == S_OUT_COMMIT);
    assign timeout_hit = waiting && (cnt_q == (TIMEOUT - 12'd1));

    always_comb begin
        state_d      = state_q;
        nak_d        = nak_q;
        stall_d      = stall_q;
        sel_d        = sel_q;
        commit_len_d = commit_len_q;
        tx_len_d     = tx_len_q;
        hs_pid_d     = hs_pid_q;
        tx_start_d   = 1'b0;
        hs_send_d    = 1'b0;
        toggle_d     = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tok_valid && tok_legal) begin
                    sel_d   = tok_endp;
                    stall_d = ep_halted && (tok_pid != PID_SETUP);
                    if (tok_pid == PID_IN) begin
                        state_d = S_IN_CHK;
                    end else begin
                        state_d = S_OUT_RX;
                        nak_d   = (tok_pid == PID_OUT) && !buf_in_ready;
                    end
                end
            end
            S_IN_CHK: begin
                state_d = S_IDLE;
                if (stall_q) begin
                    hs_send_d = 1'b1;
                    hs_pid_d  = HS_STALL;
                end else if (buf_out_hasdata) begin
                    tx_start_d = 1'b1;
                    tx_len_d   = buf_out_len;
                    state_d    = S_IN_TX;
                end else begin
                    hs_send_d = 1'b1;
                    hs_pid_d  = HS_NAK;
                end
            end
            S_IN_TX: begin
                if (tx_done) begin
                    state_d = S_IN_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_IN_WAIT: begin
                if (hs_rx_ack) begin
                    state_d = S_IN_ARM;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_IN_ARM: begin
                if (buf_out_arm_ack) begin
                    state_d  = S_IDLE;
                    toggle_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_OUT_RX: begin
                if (rx_done) begin
                    state_d = S_IDLE;
                    // A corrupted packet gets no handshake so the host retries.
                    if (rx_crc_ok) begin
                        if (stall_q) begin
                            hs_send_d = 1'b1;
                            hs_pid_d  = HS_STALL;
                        end else if (nak_q) begin
                            hs_send_d = 1'b1;
                            hs_pid_d  = HS_NAK;
                        end else begin
                            commit_len_d = rx_len;
                            state_d      = S_OUT_COMMIT;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_OUT_COMMIT: begin
                if (buf_in_commit_ack) begin
                    state_d   = S_IDLE;
                    hs_send_d = 1'b1;
                    hs_pid_d  = HS_ACK;
                    toggle_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Cleared on every state change; saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != 12'hFFF)) begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            nak_q        <= 1'b0;
            stall_q      <= 1'b0;
            sel_q        <= '0;
            commit_len_q <= '0;
            tx_start_q   <= 1'b0;
            tx_len_q     <= '0;
            hs_send_q    <= 1'b0;
            hs_pid_q     <= '0;
            toggle_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nak_q        <= nak_d;
            stall_q      <= stall_d;
            sel_q        <= sel_d;
            commit_len_q <= commit_len_d;
            tx_start_q   <= tx_start_d;
            tx_len_q     <= tx_len_d;
            hs_send_q    <= hs_send_d;
            hs_pid_q     <= hs_pid_d;
            toggle_q     <= toggle_d;
            err_q        <= err_d;
        end
    end

    assign sel_endp          = sel_q;
    assign buf_out_arm       = (state_q == S_IN_ARM);
    assign buf_in_commit     = (state_q == S_OUT_COMMIT);
    assign buf_in_commit_len = commit_len_q;
    assign tx_start          = tx_start_q;
    assign tx_len            = tx_len_q;
    assign hs_send           = hs_send_q;
    assign hs_pid            = hs_pid_q;
    assign data_toggle_act   = toggle_q;
    assign busy              = (state_q != S_IDLE);
    assign err_timeout       = err_q;

endmodule

// File: tb/tb_usb2_ep_sched.sv
// Self-checking bench for usb2_ep_sched: directed protocol cases, timeout boundaries and randomized tokens
// checked against a transaction-level outcome model. Halt cases build when USB2_EP_SCHED_STALL_EN is defined.
module tb_usb2_ep_sched;
    localparam int TMO = 1000;

    logic        phy_clk = 1'b0;
    logic        reset = 1'b1;
    logic        tok_valid = 1'b0;
    logic [1:0]  tok_pid = '0;
    logic [3:0]  tok_endp = '0;
    logic        buf_out_hasdata = 1'b0;
    logic [9:0]  buf_out_len = '0;
    logic        buf_out_arm_ack = 1'b0;
    logic        buf_in_ready = 1'b0;
    logic        buf_in_commit_ack = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [9:0]  rx_len = '0;
    logic        rx_crc_ok = 1'b0;
    logic        hs_rx_ack = 1'b0;
    logic [3:0]  sel_endp;
    logic        buf_out_arm, buf_in_commit, tx_start, hs_send, data_toggle_act, busy, err_timeout;
    logic [9:0]  buf_in_commit_len, tx_len;
    logic [1:0]  hs_pid;
`ifdef USB2_EP_SCHED_STALL_EN
    logic        halt_set = 1'b0;
    logic        halt_clr = 1'b0;
    logic [3:0]  halt_endp = '0;
    logic [15:0] halted;
`endif

    always #5 phy_clk = ~phy_clk;

    usb2_ep_sched dut (
        .phy_clk(phy_clk), .reset(reset),
        .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_endp(tok_endp), .sel_endp(sel_endp),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len),
        .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .tx_start(tx_start), .tx_len(tx_len), .tx_done(tx_done),
        .rx_done(rx_done), .rx_len(rx_len), .rx_crc_ok(rx_crc_ok), .hs_rx_ack(hs_rx_ack),
        .hs_send(hs_send), .hs_pid(hs_pid), .data_toggle_act(data_toggle_act),
        .busy(busy), .err_timeout(err_timeout)
`ifdef USB2_EP_SCHED_STALL_EN
        , .halt_set(halt_set), .halt_clr(halt_clr), .halt_endp(halt_endp), .halted(halted)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Event monitor: cumulative counts, transactions compare deltas.
    int         n_tx = 0, n_hs = 0, n_tog = 0, n_err = 0, n_arm = 0, n_commit = 0;
    logic [9:0] last_tx_len = '0, last_commit_len = '0;
    logic [1:0] last_hs_pid = '0;
    logic       arm_prev = 1'b0, commit_prev = 1'b0;

    always @(negedge phy_clk) begin
        arm_prev    <= buf_out_arm;
        commit_prev <= buf_in_commit;
        if (tx_start) begin
            n_tx        <= n_tx + 1;
            last_tx_len <= tx_len;
        end
        if (hs_send) begin
            n_hs        <= n_hs + 1;
            last_hs_pid <= hs_pid;
        end
        if (data_toggle_act) n_tog <= n_tog + 1;
        if (err_timeout) n_err <= n_err + 1;
        if (buf_out_arm && !arm_prev) n_arm <= n_arm + 1;
        if (buf_in_commit && !commit_prev) begin
            n_commit        <= n_commit + 1;
            last_commit_len <= buf_in_commit_len;
        end
    end

    // Reference halt state; stays all-zero unless the halt feature is built.
    logic [15:0] m_halted = '0;
    logic [15:0] m_in_mask = 16'h0003;
    logic [15:0] m_out_mask = 16'h0005;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {sel_endp, buf_out_arm, buf_in_commit, buf_in_commit_len, tx_start, tx_len,
                hs_send, hs_pid, data_toggle_act, busy, err_timeout};
    endfunction

    task automatic run_txn(input logic [1:0] pid, input logic [3:0] endp, input logic hasdata,
                           input logic [9:0] len, input logic ready, input logic crc, input string tag);
        int b_tx, b_hs, b_tog, b_arm, b_commit, b_err;
        int e_tx, e_hs, e_tog, e_arm, e_commit;
        logic [1:0] e_pid;
        logic legal, halted_ep;
        int guard;
        e_tx = 0; e_hs = 0; e_tog = 0; e_arm = 0; e_commit = 0; e_pid = 2'd0;
        legal = (pid == 2'd1) ? m_in_mask[endp] :
                (pid == 2'd0) ? m_out_mask[endp] :
                (pid == 2'd2) ? (endp == 4'd0) : 1'b0;
        if (legal) begin
            if (pid == 2'd2) m_halted[0] = 1'b0;
            halted_ep = m_halted[endp] && (pid != 2'd2);
            if (pid == 2'd1) begin
                if (halted_ep)    begin e_hs = 1; e_pid = 2'd2; end
                else if (hasdata) begin e_tx = 1; e_arm = 1; e_tog = 1; end
                else              begin e_hs = 1; e_pid = 2'd1; end
            end else if (crc) begin
                if (halted_ep)                     begin e_hs = 1; e_pid = 2'd2; end
                else if (pid == 2'd0 && !ready)    begin e_hs = 1; e_pid = 2'd1; end
                else begin e_commit = 1; e_hs = 1; e_pid = 2'd0; e_tog = 1; end
            end
        end
        b_tx = n_tx; b_hs = n_hs; b_tog = n_tog; b_arm = n_arm; b_commit = n_commit; b_err = n_err;

        tok_valid = 1'b1; tok_pid = pid; tok_endp = endp;
        buf_out_hasdata = hasdata; buf_out_len = len; buf_in_ready = ready;
        tick();
        tok_valid = 1'b0;
        check({tag, ".busy_after_tok"}, busy, legal);
        if (legal) check({tag, ".sel_endp"}, sel_endp, endp);

        if (pid == 2'd1) begin
            tick();
            check({tag, ".tx_start_1cyc"}, tx_start, e_tx);
            check({tag, ".hs_after_chk"}, hs_send, e_hs);
            if (tx_start) begin
                repeat ($urandom_range(0, 3)) tick();
                tx_done = 1'b1; tick(); tx_done = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
                hs_rx_ack = 1'b1; tick(); hs_rx_ack = 1'b0;
                check({tag, ".arm_rise"}, buf_out_arm, 1);
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    check({tag, ".arm_hold"}, buf_out_arm, 1);
                end
                buf_out_arm_ack = 1'b1; tick(); buf_out_arm_ack = 1'b0;
                check({tag, ".arm_drop"}, buf_out_arm, 0);
                check({tag, ".toggle_with_drop"}, data_toggle_act, 1);
            end
        end else if (pid != 2'd3) begin
            repeat ($urandom_range(0, 3)) tick();
            rx_len = len; rx_crc_ok = crc; rx_done = 1'b1; tick(); rx_done = 1'b0;
            check({tag, ".hs_after_rx"}, hs_send, (e_hs != 0) && (e_commit == 0));
            check({tag, ".commit_rise"}, buf_in_commit, e_commit);
            if (buf_in_commit) begin
                check({tag, ".commit_len"}, buf_in_commit_len, len);
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    check({tag, ".commit_hold"}, buf_in_commit, 1);
                end
                buf_in_commit_ack = 1'b1; tick(); buf_in_commit_ack = 1'b0;
                check({tag, ".commit_drop"}, buf_in_commit, 0);
                check({tag, ".ack_with_drop"}, {hs_send, hs_pid, data_toggle_act}, {1'b1, 2'd0, 1'b1});
            end
        end else begin
            tick();
        end

        guard = 0;
        while (busy && guard < 10) begin tick(); guard++; end
        check({tag, ".idle_reached"}, busy, 0);
        tick();
        check({tag, ".n_tx"}, n_tx - b_tx, e_tx);
        if (e_tx != 0) check({tag, ".tx_len"}, last_tx_len, len);
        check({tag, ".n_hs"}, n_hs - b_hs, e_hs);
        if (e_hs != 0) check({tag, ".hs_pid"}, last_hs_pid, e_pid);
        check({tag, ".n_toggle"}, n_tog - b_tog, e_tog);
        check({tag, ".n_arm"}, n_arm - b_arm, e_arm);
        check({tag, ".n_commit"}, n_commit - b_commit, e_commit);
        if (e_commit != 0) check({tag, ".commit_len_mon"}, last_commit_len, len);
        check({tag, ".n_err"}, n_err - b_err, 0);
        $display("txn %s pid=%0d ep=%0d hasdata=%0d len=%0d ready=%0d crc=%0d exp tx=%0d hs=%0d/%0d tog=%0d commit=%0d",
                 tag, pid, endp, hasdata, len, ready, crc, e_tx, e_hs, e_pid, e_tog, e_commit);
    endtask

    // Drives an IN up to the point where IN_WAIT has just been entered.
    task automatic in_to_wait();
        tok_valid = 1'b1; tok_pid = 2'd1; tok_endp = 4'd1; buf_out_hasdata = 1'b1; buf_out_len = 10'd32;
        tick();
        tok_valid = 1'b0;
        tick();
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, b_tog, b_hs, b_arm, b_err;
        logic seen_arm;

        repeat (3) tick();
        check("reset.outputs", all_outputs(), 64'd0);
        reset = 1'b0;
        tick();
        check("idle.outputs", all_outputs(), 64'd0);

        run_txn(2'd1, 4'd1, 1'b1, 10'd64,  1'b0, 1'b1, "in_ep1_data");
        run_txn(2'd1, 4'd1, 1'b0, 10'd64,  1'b0, 1'b1, "in_ep1_nak");
        run_txn(2'd0, 4'd2, 1'b0, 10'd512, 1'b1, 1'b1, "out_ep2_ack");
        run_txn(2'd0, 4'd2, 1'b0, 10'd512, 1'b0, 1'b1, "out_ep2_nak");
        run_txn(2'd2, 4'd0, 1'b0, 10'd8,   1'b0, 1'b1, "setup_ep0");
        run_txn(2'd2, 4'd2, 1'b0, 10'd8,   1'b1, 1'b1, "setup_ep2_ign");
        run_txn(2'd3, 4'd0, 1'b1, 10'd8,   1'b1, 1'b1, "pid3_ign");
        run_txn(2'd1, 4'd2, 1'b1, 10'd8,   1'b1, 1'b1, "in_ep2_ign");
        run_txn(2'd1, 4'd0, 1'b1, 10'd0,   1'b1, 1'b1, "in_zlp");
        run_txn(2'd0, 4'd0, 1'b0, 10'd0,   1'b1, 1'b1, "out_zlp");
        run_txn(2'd0, 4'd0, 1'b0, 10'd9,   1'b1, 1'b0, "out_badcrc");

        // IN without host ACK: abort exactly TMO cycles after entering IN_WAIT.
        b_tog = n_tog; b_hs = n_hs; b_arm = n_arm;
        in_to_wait();
        k = 0; seen_arm = 1'b0;
        while (!err_timeout && k < TMO + 5) begin
            tick(); k++;
            if (buf_out_arm) seen_arm = 1'b1;
        end
        check("tmo.cycles", k, TMO);
        check("tmo.busy", busy, 0);
        tick();
        check("tmo.pulse_width", err_timeout, 0);
        check("tmo.no_arm", {seen_arm, 32'(n_arm - b_arm)}, 0);
        check("tmo.no_toggle_hs", {32'(n_tog - b_tog), 32'(n_hs - b_hs)}, 0);
        $display("txn in_timeout cycles=%0d", k);

        // Host ACK arriving on the last allowed cycle wins over the timeout.
        b_err = n_err;
        in_to_wait();
        repeat (TMO - 1) tick();
        hs_rx_ack = 1'b1; tick(); hs_rx_ack = 1'b0;
        check("tmo_edge.no_err", err_timeout, 0);
        check("tmo_edge.arm", buf_out_arm, 1);
        buf_out_arm_ack = 1'b1; tick(); buf_out_arm_ack = 1'b0;
        check("tmo_edge.toggle", data_toggle_act, 1);
        tick();
        check("tmo_edge.n_err", n_err - b_err, 0);
        $display("txn in_ack_at_timeout_edge");

        // Reset during OUT_COMMIT drops everything at the next edge.
        b_tog = n_tog; b_hs = n_hs;
        tok_valid = 1'b1; tok_pid = 2'd0; tok_endp = 4'd2; buf_in_ready = 1'b1;
        tick();
        tok_valid = 1'b0;
        rx_len = 10'd100; rx_crc_ok = 1'b1; rx_done = 1'b1; tick(); rx_done = 1'b0;
        check("rst_mid.commit_up", buf_in_commit, 1);
        reset = 1'b1; tick();
        check("rst_mid.outputs", all_outputs(), 64'd0);
        reset = 1'b0; tick();
        check("rst_mid.no_toggle_hs", {32'(n_tog - b_tog), 32'(n_hs - b_hs)}, 0);
        $display("txn reset_in_commit");

        for (int i = 0; i < 40; i++) begin
            logic [1:0] p;
            logic [9:0] l;
            p = 2'($urandom_range(0, 3));
            l = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            run_txn(p, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), l,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0), "rand");
        end

`ifdef USB2_EP_SCHED_STALL_EN
        halt_set = 1'b1; halt_endp = 4'd2; tick(); halt_set = 1'b0;
        m_halted[2] = 1'b1;
        check("halt.set_ep2", halted[2], 1);
        run_txn(2'd0, 4'd2, 1'b0, 10'd16, 1'b1, 1'b1, "out_ep2_stall");
        halt_set = 1'b1; halt_clr = 1'b1; halt_endp = 4'd1; tick(); halt_set = 1'b0; halt_clr = 1'b0;
        check("halt.clr_wins", halted[1], 0);
        run_txn(2'd1, 4'd1, 1'b1, 10'd4, 1'b1, 1'b1, "in_ep1_not_halted");
        halt_set = 1'b1; halt_endp = 4'd0; tick(); halt_set = 1'b0;
        m_halted[0] = 1'b1;
        check("halt.set_ep0", halted[0], 1);
        run_txn(2'd2, 4'd0, 1'b0, 10'd8, 1'b0, 1'b1, "setup_clears_halt");
        check("halt.setup_cleared", halted[0], 0);
        halt_clr = 1'b1; halt_endp = 4'd2; tick(); halt_clr = 1'b0;
        m_halted[2] = 1'b0;
        check("halt.clr_ep2", halted, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
